seg7_scan_driver: RTL and testbench

- Downstream display stage for the 4-bit counters. Takes NUM_DIGITS 4-bit values (e.g. counter q outputs) and drives a time-multiplexed common-anode 7-segment display.
- Includes a refresh prescaler, digit-slot rotation, per-frame input snapshot (no tearing), per-slot anode dead time (no ghosting), blanking and decimal points.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_hex_decode.sv | 9 +
 rtl/seg7_scan_driver.sv | 76 +++++++
 tb/tb_seg7_scan_driver.sv | 116 +++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment width, hex-to-segment table and polarity helpers
package seg7_pkg;
  localparam int SEG_W = 7;
  // entry k holds the active-high g..a pattern for hex digit k (entry 15 first)
  localparam logic [16*SEG_W-1:0] HEX_TBL = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [SEG_W-1:0] hex_seg(input logic [3:0] d);
    return HEX_TBL[int'(d)*SEG_W +: SEG_W];
  endfunction
  function automatic logic [SEG_W-1:0] seg_off(input bit active_low);
    return active_low ? '1 : '0;
  endfunction
  // wide enough for the largest display; callers slice to their digit count
  function automatic logic [7:0] an_off(input bit active_low);
    return {8{active_low}};
  endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: 4-bit value to active-high g..a segment pattern
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg
);
  assign seg = hex_seg(digit);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment driver with frame snapshot and anode dead time
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [7:0] AN_OFF8 = an_off(ACTIVE_LOW);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_OFF8[NUM_DIGITS-1:0];
  localparam logic [SEG_W-1:0] SEG_OFF = seg_off(ACTIVE_LOW);

  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx, idx_n;
  logic [4*NUM_DIGITS-1:0] dig_sh, dig_n;
  logic [NUM_DIGITS-1:0]   blank_sh, blank_n, dp_sh, dp_n, onehot;
  logic                    first, load, lit;
  logic [3:0]              hex_digit;
  logic [SEG_W-1:0]        hex_raw;

  seg7_hex_decode u_dec (.digit(hex_digit), .seg(hex_raw));

  // next scan position and shadows; outputs are derived from these so they line up with the new (idx,cnt)
  always_comb begin
    load      = first | (cnt == CNT_MAX && idx == IDX_MAX);
    cnt_n     = cnt == CNT_MAX ? '0 : cnt + 1'b1;
    idx_n     = cnt != CNT_MAX ? idx : idx == IDX_MAX ? '0 : idx + 1'b1;
    dig_n     = load ? digits_in : dig_sh;
    blank_n   = load ? blank_mask : blank_sh;
    dp_n      = load ? dp_in : dp_sh;
    hex_digit = dig_n[{idx_n, 2'b00} +: 4];
    lit       = cnt_n != '0 && !blank_n[idx_n];
    onehot    = NUM_DIGITS'(1) << idx_n;
  end

  // scan state, shadows and registered (polarity-adjusted) outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      dig_sh     <= '0;
      blank_sh   <= '0;
      dp_sh      <= '0;
      first      <= 1'b1;
      seg        <= SEG_OFF;
      dp         <= ACTIVE_LOW;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      idx        <= idx_n;
      dig_sh     <= dig_n;
      blank_sh   <= blank_n;
      dp_sh      <= dp_n;
      first      <= 1'b0;
      seg        <= (lit ? hex_raw : '0) ^ SEG_OFF;
      dp         <= (lit & dp_n[idx_n]) ^ ACTIVE_LOW;
      an         <= (lit ? onehot : '0) ^ AN_OFF;
      frame_tick <= load;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for the 4-digit, 4-cycle-slot, active-low configuration
module tb_seg7_scan_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask, dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  localparam exp_t OFF = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0};
  localparam logic [3:0] AN_ON [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] SEG_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  localparam logic [6:0] SEG_FEDC [4] = '{7'h46, 7'h21, 7'h06, 7'h0E};

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         e = 0;
  logic [6:0] cur_seg[4], nxt_seg[4];
  logic [3:0] cur_blank, nxt_blank, cur_dp, nxt_dp;

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .blank_mask(blank_mask), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // edge k after reset release: slot (k/4)%4, position k%4 within the slot
  function automatic exp_t model(int k);
    int c, s;
    logic ft;
    c  = k % 4;
    s  = (k / 4) % 4;
    ft = (k == 1) || (k % 16 == 0);
    if (c == 0 || cur_blank[s]) return '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: ft};
    return '{an: AN_ON[s], seg: cur_seg[s], dp: ~cur_dp[s], ft: ft};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      e++;
      if (e == 1 || e % 16 == 0) begin
        cur_seg   = nxt_seg;
        cur_blank = nxt_blank;
        cur_dp    = nxt_dp;
      end
    end
    #1 q.push_back(rst ? OFF : model(e));
  endtask

  task automatic run_to(int k);
    while (e < k) tick();
  endtask

  // monitor: compare the oldest expectation against the outputs mid-cycle
  always @(negedge clk) begin
    exp_t x;
    if (q.size() != 0) begin
      x = q.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== x) begin
        errors++;
        $display("FAIL outputs e=%0d got an=%b seg=%h dp=%b ft=%b expected an=%b seg=%h dp=%b ft=%b",
                 e, an, seg, dp, frame_tick, x.an, x.seg, x.dp, x.ft);
      end
    end
  end

  initial begin
    digits_in  = 16'h1234;
    blank_mask = 4'b0000;
    dp_in      = 4'b0000;
    nxt_seg    = SEG_1234;
    nxt_blank  = 4'b0000;
    nxt_dp     = 4'b0000;
    cur_seg    = SEG_1234;
    cur_blank  = 4'b0000;
    cur_dp     = 4'b0000;
    repeat (3) tick();
    @(negedge clk) rst = 1'b0;
    run_to(21);
    digits_in = 16'hFEDC;
    nxt_seg   = SEG_FEDC;
    run_to(40);
    blank_mask = 4'b0100;
    dp_in      = 4'b0001;
    nxt_blank  = 4'b0100;
    nxt_dp     = 4'b0001;
    run_to(73);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 q.push_back(OFF);
    repeat (3) tick();
    @(negedge clk) rst = 1'b0;
    e = 0;
    run_to(50);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
